tdm_demux_8x2: RTL and testbench

//   Receive end of the 8x2 mux link: time-division demultiplexer that rebuilds eight

---
 rtl/tdm_demux_8x2_if.sv | 47 ++++
 rtl/tdm_demux_8x2.sv | 114 +++++++++++
 tb/tb_tdm_demux_8x2.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/tdm_demux_8x2_if.sv
// Link-side bundle of the 8x2 TDM demultiplexer.
// master: the mux side plus the lane consumers. It drives the muxed streams, the
//         enables and sync, and receives the slot select and the rebuilt frame.
// slave : the demultiplexer itself.
// Signals
//   din1/din2       muxed streams (lanes 0..3 / lanes 4..7)
//   e1_n/e2_n       active-low stream enables
//   sync            frame-start marker, high in the cycle that carries slot 0
//   sela/selb       slot select, LSB/MSB
//   out0..out7      reconstructed lanes
//   frame_valid     pulse: a full frame was just published
//   sync_err        pulse: a sync mid-frame dropped the partial frame
//   locked          high while the receiver is framing
interface tdm_demux_8x2_if #(
    parameter int unsigned WIDTH = 1
);
    logic [WIDTH-1:0] din1;
    logic [WIDTH-1:0] din2;
    logic             e1_n;
    logic             e2_n;
    logic             sync;
    logic             sela;
    logic             selb;
    logic [WIDTH-1:0] out0;
    logic [WIDTH-1:0] out1;
    logic [WIDTH-1:0] out2;
    logic [WIDTH-1:0] out3;
    logic [WIDTH-1:0] out4;
    logic [WIDTH-1:0] out5;
    logic [WIDTH-1:0] out6;
    logic [WIDTH-1:0] out7;
    logic             frame_valid;
    logic             sync_err;
    logic             locked;

    modport master (
        output din1, din2, e1_n, e2_n, sync,
        input  sela, selb, out0, out1, out2, out3, out4, out5, out6, out7,
        input  frame_valid, sync_err, locked
    );

    modport slave (
        input  din1, din2, e1_n, e2_n, sync,
        output sela, selb, out0, out1, out2, out3, out4, out5, out6, out7,
        output frame_valid, sync_err, locked
    );
endinterface

// File: rtl/tdm_demux_8x2.sv
// Receive end of the 8x2 TDM link. Rebuilds eight lanes from two muxed streams
// of four slots each, drives the slot select back to the mux, and publishes
// all eight lanes together as one registered frame.
// Ports
//   clk   rising-edge clock
//   rst   synchronous, active-high reset
//   bus   tdm_demux_8x2_if.slave. It carries din1/din2, e1_n/e2_n and sync in,
//         and sela/selb, out0..out7, frame_valid, sync_err and locked out.
module tdm_demux_8x2 #(
    parameter int unsigned WIDTH = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    tdm_demux_8x2_if.slave       bus
);
    localparam int unsigned LANES = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                      state_q, state_d;
    logic [1:0]                  cnt_q, cnt_d;
    logic [LANES-1:0][WIDTH-1:0] sh_q, sh_d;
    logic [LANES-1:0][WIDTH-1:0] out_q, out_d;
    logic                        fv_q, fv_d;
    logic                        se_q, se_d;
    logic                        locked_q;
    logic [WIDTH-1:0]            cap1, cap2;

    // A disabled stream contributes zeros. The enable is taken in the same cycle as the data.
    assign cap1 = bus.din1 & {WIDTH{~bus.e1_n}};
    assign cap2 = bus.din2 & {WIDTH{~bus.e2_n}};

    // Registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= 2'd0;
            sh_q     <= '0;
            out_q    <= '0;
            fv_q     <= 1'b0;
            se_q     <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sh_q     <= sh_d;
            out_q    <= out_d;
            fv_q     <= fv_d;
            se_q     <= se_d;
            locked_q <= (state_d == RUN);
        end
    end

    // Next state: slot capture, framing and publish
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        out_d   = out_q;
        fv_d    = 1'b0;
        se_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.sync) begin
                    sh_d    = '0;
                    sh_d[0] = cap1;
                    sh_d[4] = cap2;
                    cnt_d   = 2'd1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (bus.sync && (cnt_q != 2'd0)) begin
                    // A sync in the middle of a frame drops the partial frame.
                    // This cycle is re-used as slot 0 of the new frame.
                    sh_d    = '0;
                    sh_d[0] = cap1;
                    sh_d[4] = cap2;
                    cnt_d   = 2'd1;
                    se_d    = 1'b1;
                end else begin
                    sh_d[{1'b0, cnt_q}] = cap1;
                    sh_d[{1'b1, cnt_q}] = cap2;
                    cnt_d               = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        // Slot 3 bypasses the shadow so that the whole frame updates on one edge.
                        out_d    = sh_q;
                        out_d[3] = cap1;
                        out_d[7] = cap2;
                        fv_d     = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.sela        = cnt_q[0];
    assign bus.selb        = cnt_q[1];
    assign bus.out0        = out_q[0];
    assign bus.out1        = out_q[1];
    assign bus.out2        = out_q[2];
    assign bus.out3        = out_q[3];
    assign bus.out4        = out_q[4];
    assign bus.out5        = out_q[5];
    assign bus.out6        = out_q[6];
    assign bus.out7        = out_q[7];
    assign bus.frame_valid = fv_q;
    assign bus.sync_err    = se_q;
    assign bus.locked      = locked_q;
endmodule

// File: tb/tb_tdm_demux_8x2.sv
// Directed bench for tdm_demux_8x2. A WIDTH=1 instance and a WIDTH=4 instance
// receive the same stimulus. The WIDTH=1 instance sees bit 0 of each value.
module tb_tdm_demux_8x2;
    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    logic [7:0][3:0] prev;

    always #5 clk = ~clk;

    tdm_demux_8x2_if #(.WIDTH(1)) b1 ();
    tdm_demux_8x2_if #(.WIDTH(4)) b4 ();

    tdm_demux_8x2 #(.WIDTH(1)) u_dut1 (.clk(clk), .rst(rst), .bus(b1));
    tdm_demux_8x2 #(.WIDTH(4)) u_dut4 (.clk(clk), .rst(rst), .bus(b4));

    function automatic logic [7:0] outs1();
        return {b1.out7, b1.out6, b1.out5, b1.out4, b1.out3, b1.out2, b1.out1, b1.out0};
    endfunction

    function automatic logic [31:0] outs4();
        return {b4.out7, b4.out6, b4.out5, b4.out4, b4.out3, b4.out2, b4.out1, b4.out0};
    endfunction

    function automatic logic [7:0] bit0s(input logic [7:0][3:0] f);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = f[i][0];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_frame(input string tag, input logic [7:0][3:0] exp);
        chk({tag, "_out_w1"}, 32'(outs1()), 32'(bit0s(exp)));
        chk({tag, "_out_w4"}, outs4(), 32'(exp));
    endtask

    // The control outputs, packed as {frame_valid, sync_err, selb, sela, locked}.
    task automatic chk_ctl(input string tag, input logic fv, input logic se,
                           input logic [1:0] sel, input logic lk);
        chk({tag, "_ctl_w1"}, 32'({b1.frame_valid, b1.sync_err, b1.selb, b1.sela, b1.locked}),
            32'({fv, se, sel, lk}));
        chk({tag, "_ctl_w4"}, 32'({b4.frame_valid, b4.sync_err, b4.selb, b4.sela, b4.locked}),
            32'({fv, se, sel, lk}));
    endtask

    // Apply one slot's inputs for one clock, then sample 1ns after the edge.
    task automatic step(input logic s, input logic [3:0] a, input logic [3:0] b,
                        input logic n1, input logic n2);
        b1.sync = s;  b4.sync = s;
        b1.din1 = a[0]; b4.din1 = a;
        b1.din2 = b[0]; b4.din2 = b;
        b1.e1_n = n1; b4.e1_n = n1;
        b1.e2_n = n2; b4.e2_n = n2;
        @(posedge clk);
        #1;
    endtask

    // Send four slots. Outputs hold the previous frame until slot 3 has been taken.
    task automatic send_frame(input string tag, input logic s0, input logic exp_err,
                              input logic [3:0][3:0] a, input logic [3:0][3:0] b,
                              input logic n1, input logic n2);
        logic [7:0][3:0] e;
        for (int k = 0; k < 4; k++) begin
            e[k]     = a[k] & {4{~n1}};
            e[k + 4] = b[k] & {4{~n2}};
        end
        for (int k = 0; k < 4; k++) begin
            step((k == 0) ? s0 : 1'b0, a[k], b[k], n1, n2);
            if (k < 3) begin
                chk_ctl(tag, 1'b0, (k == 0) ? exp_err : 1'b0, 2'(k + 1), 1'b1);
                chk_frame(tag, prev);
            end else begin
                chk_ctl(tag, 1'b1, 1'b0, 2'd0, 1'b1);
                chk_frame(tag, e);
                prev = e;
            end
        end
    endtask

    initial begin
        prev = '0;
        rst  = 1'b1;
        // 1: reset, then idle cycles with no sync
        step(1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
        step(1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
        chk_ctl("reset", 1'b0, 1'b0, 2'd0, 1'b0);
        chk_frame("reset", '0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 4'hF, 4'hF, 1'b0, 1'b0);
            chk_ctl("idle", 1'b0, 1'b0, 2'd0, 1'b0);
        end
        chk_frame("idle", '0);

        // 2: first frame. din1 = 1,0,1,1 and din2 = 0,1,0,0 in bit 0.
        send_frame("frame1", 1'b1, 1'b0, {4'hF, 4'h7, 4'h2, 4'h9},
                   {4'h6, 4'h8, 4'h3, 4'h4}, 1'b0, 1'b0);
        chk("frame1_const_w1", 32'(outs1()), 32'h0000_002D);
        chk("frame1_const_w4", outs4(), 32'h6834_F729);

        // 3: three back-to-back frames, with sync only on the first (aligned, so no error)
        send_frame("b2b0", 1'b1, 1'b0, {4'h1, 4'h0, 4'h3, 4'hE},
                   {4'h5, 4'hA, 4'h5, 4'hA}, 1'b0, 1'b0);
        send_frame("b2b1", 1'b0, 1'b0, {4'hC, 4'hD, 4'hB, 4'h6},
                   {4'h7, 4'h1, 4'h2, 4'h9}, 1'b0, 1'b0);
        send_frame("b2b2", 1'b0, 1'b0, {4'h0, 4'h1, 4'h0, 4'h1},
                   {4'hF, 4'hE, 4'hD, 4'hC}, 1'b0, 1'b0);

        // 4: stream 1 disabled, then stream 2 disabled
        send_frame("e1off", 1'b0, 1'b0, {4'hF, 4'hF, 4'hF, 4'hF},
                   {4'h3, 4'h2, 4'h9, 4'h8}, 1'b1, 1'b0);
        chk("e1off_const_w4", outs4(), 32'h3298_0000);
        send_frame("e2off", 1'b0, 1'b0, {4'h5, 4'h4, 4'hB, 4'hA},
                   {4'hF, 4'hF, 4'hF, 4'hF}, 1'b0, 1'b1);
        chk("e2off_const_w4", outs4(), 32'h0000_54BA);

        // 5: sync arrives again at cnt=2. The partial frame is dropped and the frame realigns.
        step(1'b0, 4'h9, 4'h9, 1'b0, 1'b0);
        step(1'b0, 4'h9, 4'h9, 1'b0, 1'b0);
        chk_ctl("pre_resync", 1'b0, 1'b0, 2'd2, 1'b1);
        send_frame("resync", 1'b1, 1'b1, {4'h8, 4'h3, 4'hC, 4'h7},
                   {4'h2, 4'hD, 4'h6, 4'h1}, 1'b0, 1'b0);
        chk("resync_const_w4", outs4(), 32'h2D61_83C7);

        // 6: reset at cnt=2 in the middle of a frame, then relock
        step(1'b1, 4'hA, 4'hA, 1'b0, 1'b0);
        step(1'b0, 4'hB, 4'hB, 1'b0, 1'b0);
        rst = 1'b1;
        step(1'b0, 4'hC, 4'hC, 1'b0, 1'b0);
        chk_ctl("midrst", 1'b0, 1'b0, 2'd0, 1'b0);
        chk_frame("midrst", '0);
        rst  = 1'b0;
        prev = '0;
        step(1'b0, 4'hD, 4'hD, 1'b0, 1'b0);
        chk_ctl("postrst", 1'b0, 1'b0, 2'd0, 1'b0);
        send_frame("relock", 1'b1, 1'b0, {4'hE, 4'h5, 4'hA, 4'h3},
                   {4'h1, 4'h6, 4'h9, 4'hC}, 1'b0, 1'b0);
        chk("relock_const_w4", outs4(), 32'h169C_E5A3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
